// File: rtl/mux_select_arbiter.sv
// ---------------------------------------------------------------------------
// mux_select_arbiter
//   Round-robin arbiter for one shared 4:1, 32-bit datapath mux. It picks an
//   owner among four requesters, drives the mux select, and presents the
//   owner's beat downstream with a valid/ready handshake. A wait watchdog
//   releases an owner that has been stalled for TIMEOUT_CYCLES cycles.
//
// Parameters
//   TIMEOUT_CYCLES  consecutive stalled cycles allowed per grant (0 = off)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   Req_i[3:0]  request vector, held until the matching Ack_o bit is seen
//   Ready_i     downstream accepts the current beat this cycle
//   Selector_o  mux select = index of current owner (held while idle)
//   Valid_o     beat on the mux output is valid (arbiter is granting)
//   Grant_o     one-hot current owner, 0 when idle
//   Ack_o       one-hot beat-accepted strobe, Grant_o & {4{Ready_i}}
//   Timeout_o   one-cycle pulse: grant abandoned by the watchdog
// ---------------------------------------------------------------------------
module mux_select_arbiter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Req_i,
   input  logic       Ready_i,
   output logic [1:0] Selector_o,
   output logic       Valid_o,
   output logic [3:0] Grant_o,
   output logic [3:0] Ack_o,
   output logic       Timeout_o
);

   // Width is kept at least 1 so a disabled watchdog still elaborates.
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] WCNT_LAST =
      (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t           state_reg,   state_next;
   logic [1:0]       own_reg,     own_next;
   logic [1:0]       prio_reg,    prio_next;
   logic [CNT_W-1:0] wcnt_reg,    wcnt_next;
   logic             timeout_reg, timeout_next;

   logic [1:0] own_inc;
   logic [3:0] own_mask;
   logic [3:0] remaining;

   // First set bit of cand scanning start, start+1, ... (mod 4). The loop runs
   // from the farthest offset down so the nearest candidate is written last.
   // Result is meaningless when cand is zero; callers check |cand first.
   function automatic logic [1:0] pick(input logic [3:0] cand, input logic [1:0] start);
      logic [1:0] idx;
      logic [1:0] res;
      res = start;
      for (int i = 3; i >= 0; i--) begin
         idx = start + 2'(i);
         if (cand[idx]) res = idx;
      end
      return res;
   endfunction

   assign own_inc   = own_reg + 2'd1;
   assign own_mask  = 4'b0001 << own_reg;
   assign remaining = Req_i & ~own_mask;

   always_comb begin
      state_next   = state_reg;
      own_next     = own_reg;
      prio_next    = prio_reg;
      wcnt_next    = wcnt_reg;
      timeout_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (|Req_i) begin
               own_next   = pick(Req_i, prio_reg);
               state_next = GRANT;
               wcnt_next  = '0;
            end
         end
         GRANT: begin
            if (Ready_i) begin
               // Beat accepted: hand over immediately so there is no bubble.
               prio_next = own_inc;
               if (|remaining) begin
                  own_next  = pick(remaining, own_inc);
                  wcnt_next = '0;
               end else begin
                  state_next = IDLE;
               end
            end else if (!Req_i[own_reg]) begin
               prio_next  = own_inc;
               state_next = IDLE;
            end else begin
               wcnt_next = wcnt_reg + CNT_W'(1);
               if (TIMEOUT_CYCLES != 0 && wcnt_reg == WCNT_LAST) begin
                  prio_next    = own_inc;
                  state_next   = IDLE;
                  timeout_next = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         own_reg     <= 2'd0;
         prio_reg    <= 2'd0;
         wcnt_reg    <= '0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         own_reg     <= own_next;
         prio_reg    <= prio_next;
         wcnt_reg    <= wcnt_next;
         timeout_reg <= timeout_next;
      end
   end

   assign Selector_o = own_reg;
   assign Valid_o    = (state_reg == GRANT);
   assign Timeout_o  = timeout_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_port
         assign Grant_o[gi] = (state_reg == GRANT) && (own_reg == 2'(gi));
         assign Ack_o[gi]   = Grant_o[gi] & Ready_i;
      end
   endgenerate

endmodule

// File: tb/tb_mux_select_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_select_arbiter
//   Directed bench for mux_select_arbiter (watchdog set to 4 cycles). A
//   behavioural model, stepped on every rising edge, predicts all outputs and
//   is compared on every falling edge; directed sequences add hand-computed
//   literal expectations at posedge+3.
// ---------------------------------------------------------------------------
module tb_mux_select_arbiter;

   localparam int T = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Req_i;
   logic       Ready_i;
   logic [1:0] Selector_o;
   logic       Valid_o;
   logic [3:0] Grant_o;
   logic [3:0] Ack_o;
   logic       Timeout_o;

   int tests = 0;
   int fails = 0;

   mux_select_arbiter #(.TIMEOUT_CYCLES(T)) dut (
      .clk        (clk),
      .reset      (reset),
      .Req_i      (Req_i),
      .Ready_i    (Ready_i),
      .Selector_o (Selector_o),
      .Valid_o    (Valid_o),
      .Grant_o    (Grant_o),
      .Ack_o      (Ack_o),
      .Timeout_o  (Timeout_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit busy;    // some port owns the path
      int own;     // owner index, kept while idle
      int prio;    // round-robin start point
      int stall;   // stalled cycles seen in the current grant
      bit to;      // watchdog fired on the last edge
   } mstate_t;

   mstate_t m;

   function automatic int pick(input logic [3:0] v, input int start);
      for (int k = 0; k < 4; k++)
         if (v[(start + k) % 4]) return (start + k) % 4;
      return -1;
   endfunction

   function automatic mstate_t model_step(input mstate_t s, input logic rst,
                                          input logic [3:0] req, input logic rdy);
      mstate_t n;
      logic [3:0] rest;
      n = s;
      n.to = 1'b0;
      if (rst) begin
         n.busy = 1'b0; n.own = 0; n.prio = 0; n.stall = 0;
      end else if (!s.busy) begin
         if (req != 4'b0) begin
            n.own = pick(req, s.prio); n.busy = 1'b1; n.stall = 0;
         end
      end else if (rdy) begin
         n.prio = (s.own + 1) % 4;
         rest = req & ~(4'b0001 << s.own);
         if (rest != 4'b0) begin
            n.own = pick(rest, n.prio); n.stall = 0;
         end else begin
            n.busy = 1'b0;
         end
      end else if (!req[s.own]) begin
         n.prio = (s.own + 1) % 4; n.busy = 1'b0;
      end else begin
         n.stall = s.stall + 1;
         if (T != 0 && n.stall == T) begin
            n.prio = (s.own + 1) % 4; n.busy = 1'b0; n.to = 1'b1;
         end
      end
      return n;
   endfunction

   always @(posedge clk) m <= model_step(m, reset, Req_i, Ready_i);

   // Per-cycle comparison against the model (starts once reset has been sampled).
   initial begin
      logic [3:0] eg;
      @(posedge clk);
      forever begin
         @(negedge clk);
         eg = m.busy ? (4'b0001 << m.own) : 4'b0000;
         check("m_valid",   32'(Valid_o),    32'(m.busy));
         check("m_sel",     32'(Selector_o), 32'(m.own));
         check("m_grant",   32'(Grant_o),    32'(eg));
         check("m_ack",     32'(Ack_o),      32'(Ready_i ? eg : 4'b0000));
         check("m_timeout", 32'(Timeout_o),  32'(m.to));
      end
   end

   // Apply inputs for the cycle following the next rising edge, then settle.
   task automatic cyc(input logic [3:0] r, input logic rd, input logic rs);
      @(posedge clk);
      #1;
      Req_i = r; Ready_i = rd; reset = rs;
      #2;
   endtask

   task automatic do_reset();
      cyc(4'b0000, 1'b0, 1'b1);
      cyc(4'b0000, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; Req_i = 4'b0000; Ready_i = 1'b0;
      repeat (2) @(posedge clk);
      cyc(4'b0000, 1'b0, 1'b0);
      check("rst_valid",   32'(Valid_o),    32'd0);
      check("rst_sel",     32'(Selector_o), 32'd0);
      check("rst_grant",   32'(Grant_o),    32'd0);
      check("rst_timeout", 32'(Timeout_o),  32'd0);

      // 1: single request, accepted at once, then idle with select held
      cyc(4'b0100, 1'b1, 1'b0);
      check("t1_idle_before", 32'(Valid_o), 32'd0);
      cyc(4'b0100, 1'b1, 1'b0);
      check("t1_valid", 32'(Valid_o),    32'd1);
      check("t1_sel",   32'(Selector_o), 32'd2);
      check("t1_ack",   32'(Ack_o),      32'b0100);
      cyc(4'b0000, 1'b0, 1'b0);
      check("t1_idle",     32'(Valid_o),    32'd0);
      check("t1_sel_hold", 32'(Selector_o), 32'd2);

      // 2: all four request, back-to-back grants 0,1,2,3
      do_reset();
      cyc(4'b1111, 1'b1, 1'b0);
      cyc(4'b1110, 1'b1, 1'b0);
      check("t2_sel0", 32'(Selector_o), 32'd0);
      check("t2_ack0", 32'(Ack_o),      32'b0001);
      cyc(4'b1100, 1'b1, 1'b0);
      check("t2_sel1", 32'(Selector_o), 32'd1);
      cyc(4'b1000, 1'b1, 1'b0);
      check("t2_sel2", 32'(Selector_o), 32'd2);
      cyc(4'b0000, 1'b0, 1'b0);
      check("t2_sel3",   32'(Selector_o), 32'd3);
      check("t2_valid3", 32'(Valid_o),    32'd1);
      cyc(4'b0000, 1'b0, 1'b0);
      check("t2_idle", 32'(Valid_o), 32'd0);

      // 3: ports 0 and 2 keep requesting, grants alternate
      do_reset();
      cyc(4'b0101, 1'b1, 1'b0);
      cyc(4'b0101, 1'b1, 1'b0);
      check("t3_g0", 32'(Selector_o), 32'd0);
      cyc(4'b0101, 1'b1, 1'b0);
      check("t3_g2", 32'(Selector_o), 32'd2);
      cyc(4'b0101, 1'b1, 1'b0);
      check("t3_g0b", 32'(Selector_o), 32'd0);
      cyc(4'b0101, 1'b1, 1'b0);
      check("t3_g2b", 32'(Grant_o), 32'b0100);
      cyc(4'b0000, 1'b0, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);
      check("t3_idle", 32'(Valid_o), 32'd0);

      // 4: watchdog, owner 0 stalls for T cycles, next grant goes to port 1
      do_reset();
      cyc(4'b0011, 1'b0, 1'b0);
      for (int i = 0; i < T; i++) begin
         cyc(4'b0011, 1'b0, 1'b0);
         check("t4_stall_valid", 32'(Valid_o),   32'd1);
         check("t4_stall_sel",   32'(Selector_o), 32'd0);
         check("t4_no_to",       32'(Timeout_o), 32'd0);
      end
      cyc(4'b0011, 1'b0, 1'b0);
      check("t4_released", 32'(Valid_o),   32'd0);
      check("t4_timeout",  32'(Timeout_o), 32'd1);
      check("t4_no_ack",   32'(Ack_o),     32'd0);
      cyc(4'b0011, 1'b1, 1'b0);
      check("t4_next_sel", 32'(Selector_o), 32'd1);
      check("t4_to_pulse", 32'(Timeout_o),  32'd0);
      check("t4_ack1",     32'(Ack_o),      32'b0010);

      // 5: owner 3 withdraws while stalled, then accepted-on-drop variant
      do_reset();
      cyc(4'b1000, 1'b0, 1'b0);
      cyc(4'b1000, 1'b0, 1'b0);
      check("t5_own3", 32'(Selector_o), 32'd3);
      cyc(4'b0000, 1'b0, 1'b0);
      check("t5_no_ack", 32'(Ack_o), 32'd0);
      cyc(4'b0000, 1'b0, 1'b0);
      check("t5_idle", 32'(Valid_o), 32'd0);
      cyc(4'b1000, 1'b0, 1'b0);
      cyc(4'b0000, 1'b1, 1'b0);
      check("t5_ack_drop", 32'(Ack_o), 32'b1000);
      cyc(4'b1111, 1'b1, 1'b0);
      check("t5_idle2", 32'(Valid_o), 32'd0);
      cyc(4'b1110, 1'b1, 1'b0);
      check("t5_prio0", 32'(Selector_o), 32'd0);
      cyc(4'b0000, 1'b0, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);

      // 6: reset mid-grant with wcnt=2, then 1-cycle latency grant
      do_reset();
      cyc(4'b0010, 1'b0, 1'b0);
      cyc(4'b0010, 1'b0, 1'b0);
      cyc(4'b0010, 1'b0, 1'b0);
      cyc(4'b0010, 1'b0, 1'b1);
      check("t6_pre_valid", 32'(Valid_o), 32'd1);
      cyc(4'b0010, 1'b1, 1'b0);
      check("t6_rst_valid",   32'(Valid_o),    32'd0);
      check("t6_rst_sel",     32'(Selector_o), 32'd0);
      check("t6_rst_grant",   32'(Grant_o),    32'd0);
      check("t6_rst_ack",     32'(Ack_o),      32'd0);
      check("t6_rst_timeout", 32'(Timeout_o),  32'd0);
      cyc(4'b0000, 1'b1, 1'b0);
      check("t6_latency", 32'(Grant_o), 32'b0010);
      check("t6_ack",     32'(Ack_o),   32'b0010);
      cyc(4'b0000, 1'b0, 1'b0);
      check("t6_idle", 32'(Valid_o), 32'd0);

      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
